// File: rtl/_fifo8way16.sv
// -----------------------------------------------------------------------------
// _fifo8way16
//
// Eight-entry, 16-bit first-word-fall-through FIFO. Eight storage registers
// are loaded through a write-pointer decode. An 8-way read mux, steered by the
// read pointer, presents the head entry on out_data. The FIFO sits between a
// 16-bit producer and a consumer, with a valid/ready handshake on each side.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid depend only on stored state, never on the
// partner's valid/ready, so there is no combinational path through the FIFO.
// A producer stalled by in_ready = 0 must hold in_data stable. out_data is
// stable while out_valid = 1 and out_ready = 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers, count and storage
//   in_data    word offered by the producer
//   in_valid   producer has a word on in_data
//   in_ready   FIFO can accept a word (count != 8)
//   out_data   head entry, mem[rp]
//   out_valid  out_data holds a valid entry (count != 0)
//   out_ready  consumer takes the head entry this cycle
//   count      number of stored entries, 0..8
// -----------------------------------------------------------------------------
module _fifo8way16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  count
);

    logic [15:0] mem [8];
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic [3:0]  cnt;

    logic        push;
    logic        pop;
    logic [7:0]  wr_en;

    // Pointers carry no wrap bit. Full and empty are told apart by cnt alone.
    assign in_ready  = (cnt != 4'd8);
    assign out_valid = (cnt != 4'd0);
    assign count     = cnt;

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // One-hot write decode: only the register addressed by wp loads, and only
    // on a push.
    always_comb begin
        wr_en = 8'h00;
        if (push) begin
            wr_en[wp] = 1'b1;
        end
    end

    // 8-way read mux selected by the read pointer.
    always_comb begin
        out_data = 16'h0000;
        case (rp)
            3'd0:    out_data = mem[0];
            3'd1:    out_data = mem[1];
            3'd2:    out_data = mem[2];
            3'd3:    out_data = mem[3];
            3'd4:    out_data = mem[4];
            3'd5:    out_data = mem[5];
            3'd6:    out_data = mem[6];
            3'd7:    out_data = mem[7];
            default: out_data = 16'h0000;
        endcase
    end

    // Storage registers. Reset clears them so that a reset mid-stream leaves
    // no stale entry visible on out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    mem[i] <= in_data;
                end
            end
        end
    end

    // Pointers and count. Pointer increments wrap modulo 8 naturally in 3 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= 3'd0;
            rp  <= 3'd0;
            cnt <= 4'd0;
        end else begin
            if (push) begin
                wp <= wp + 3'd1;
            end
            if (pop) begin
                rp <= rp + 3'd1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb__fifo8way16.sv
// -----------------------------------------------------------------------------
// Bench for _fifo8way16.
//
// Vectors are applied one per clock. Each record holds the inputs driven
// during a cycle and the outputs expected just after the following rising
// edge. After the table comes a streaming sequence, which checks sustained
// one-push-one-pop throughput against an expected-data queue.
// -----------------------------------------------------------------------------
module tb__fifo8way16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    _fifo8way16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic [3:0]  e_cnt;
        logic [15:0] e_od;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic iv, input logic [15:0] id,
                                input logic ordy, input logic [3:0] e_cnt,
                                input logic [15:0] e_od, input string name);
        vec_t v;
        v.rst   = rst;
        v.iv    = iv;
        v.id    = id;
        v.ordy  = ordy;
        v.e_cnt = e_cnt;
        v.e_od  = e_od;
        v.name  = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Driver task
    task automatic drive(input logic rst, input logic iv, input logic [15:0] id, input logic ordy);
        reset     = rst;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0000, 1'b0);

        // Reset and idle
        add(1, 0, 16'h0000, 0, 4'd0, 16'h0000, "reset0");
        add(1, 0, 16'h0000, 0, 4'd0, 16'h0000, "reset1");
        add(0, 0, 16'h0000, 0, 4'd0, 16'h0000, "idle");

        // Fill to full, then offer a word that must be refused
        for (int i = 0; i < 8; i++)
            add(0, 1, 16'(16'h1000 + i), 0, 4'(i + 1), 16'h1000, "fill");
        add(0, 1, 16'hDEAD, 0, 4'd8, 16'h1000, "full_refuse");

        // Drain in order. When empty, rp is back at 0 and mem0 still holds 1000.
        for (int k = 1; k <= 8; k++)
            add(0, 0, 16'h0000, 1, 4'(8 - k), (k < 8) ? 16'(16'h1000 + k) : 16'h1000, "drain");
        add(0, 0, 16'h0000, 1, 4'd0, 16'h1000, "empty_pop0");
        add(0, 0, 16'h0000, 1, 4'd0, 16'h1000, "empty_pop1");

        // Wrap-around: 5 words go into mem0..4, are popped, then 7 more go into
        // mem5,6,7,0,1,2,3.
        for (int i = 0; i < 5; i++)
            add(0, 1, 16'(16'h2000 + i), 0, 4'(i + 1), 16'h2000, "wrap_push5");
        for (int k = 1; k <= 5; k++)
            add(0, 0, 16'h0000, 1, 4'(5 - k), (k < 5) ? 16'(16'h2000 + k) : 16'h1005, "wrap_pop5");
        for (int i = 0; i < 7; i++)
            add(0, 1, 16'(16'hA000 + i), 0, 4'(i + 1), 16'hA000, "wrap_push7");
        for (int k = 1; k <= 7; k++)
            add(0, 0, 16'h0000, 1, 4'(7 - k), (k < 7) ? 16'(16'hA000 + k) : 16'h2004, "wrap_pop7");

        // Simultaneous push and pop at cnt=3, then at cnt=8 (push refused).
        // Now wp=rp=4.
        for (int i = 0; i < 3; i++)
            add(0, 1, 16'(16'hB000 + i), 0, 4'(i + 1), 16'hB000, "pp_fill3");
        add(0, 1, 16'hB003, 1, 4'd3, 16'hB001, "pp_cnt3");
        for (int i = 0; i < 5; i++)
            add(0, 1, 16'(16'hB004 + i), 0, 4'(4 + i), 16'hB001, "pp_fill8");
        add(0, 1, 16'hCAFE, 1, 4'd7, 16'hB002, "pp_cnt8");
        // CAFE would have landed in mem5. After the drain rp=5 and mem5 must
        // still hold B001.
        for (int k = 1; k <= 7; k++)
            add(0, 0, 16'h0000, 1, 4'(7 - k), (k < 7) ? 16'(16'hB002 + k) : 16'hB001, "pp_drain");

        // Push and pop together while empty: only the push happens.
        add(0, 1, 16'hC000, 1, 4'd1, 16'hC000, "pp_cnt0");
        for (int i = 1; i < 4; i++)
            add(0, 1, 16'(16'hC000 + i), 0, 4'(1 + i), 16'hC000, "pre_reset_fill");

        // Reset mid-stream with push and pop requested
        add(1, 1, 16'hEEEE, 1, 4'd0, 16'h0000, "reset_mid");
        add(0, 0, 16'h0000, 0, 4'd0, 16'h0000, "post_reset_idle");
        add(0, 1, 16'hF000, 0, 4'd1, 16'hF000, "post_reset_push");
        add(0, 0, 16'h0000, 1, 4'd0, 16'h0000, "post_reset_mem1_clear");

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].iv, vecs[k].id, vecs[k].ordy);
            @(posedge clk);
            #1;
            check({vecs[k].name, ".count"}, 16'(count), 16'(vecs[k].e_cnt));
            check({vecs[k].name, ".out_valid"}, 16'(out_valid), 16'(vecs[k].e_cnt != 4'd0));
            check({vecs[k].name, ".in_ready"}, 16'(in_ready), 16'(vecs[k].e_cnt != 4'd8));
            check({vecs[k].name, ".out_data"}, out_data, vecs[k].e_od);
        end

        // Streaming: 16 words with one push and one pop per cycle after the
        // first. The FIFO starts empty (cnt=0, rp=wp=1 after the last vector).
        for (int i = 0; i <= 16; i++) begin
            drive(1'b0, (i < 16), 16'(16'hD000 + i), (i > 0));
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream.unexpected_pop: got %h, want none", out_data);
                end else begin
                    check("stream.data", out_data, exp_q.pop_front());
                end
            end
            if (i >= 1 && i <= 15)
                check("stream.count", 16'(count), 16'd1);
            if (in_valid)
                exp_q.push_back(in_data);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("stream.leftover", 16'(exp_q.size()), 16'd0);
        check("stream.end_count", 16'(count), 16'd0);
        check("stream.end_valid", 16'(out_valid), 16'd0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/_fifo8way16.md
# _fifo8way16

Eight-entry, 16-bit first-word-fall-through FIFO built from eight 16-bit storage registers. A 3-bit write pointer selects the register to load. A 3-bit read pointer drives the sel input of an 8-way 16-bit read mux, which presents the head entry on out_data. It sits between a 16-bit producer, such as the CPU output port, and a consumer, such as a memory-mapped peripheral. It decouples the two with a valid/ready handshake on each side.

## Interface
Parameters:
- None. Width is fixed at 16 and depth at 8. Pointers are 3 bits; count is 4 bits.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- reset  input  1  — synchronous, active-high; sampled on the rising edge of clk.
- in_data  input  16  — word offered by the producer.
- in_valid  input  1  — producer has a word on in_data.
- in_ready  output  1  — FIFO can accept a word this cycle.
- out_data  output  16  — head entry, the storage register selected by the read pointer.
- out_valid  output  1  — out_data holds a valid entry.
- out_ready  input  1  — consumer takes the head entry this cycle.
- count  output  4  — number of stored entries, 0..8.

## Operation
- State:
  - storage registers mem0..mem7, 16 bits each;
  - wp[2:0], the write pointer;
  - rp[2:0], the read pointer;
  - cnt[3:0], the entry count.
- Combinational outputs:
  - in_ready = (cnt != 8).
  - out_valid = (cnt != 0).
  - count = cnt.
  - out_data = mem[rp], through the 8-way 16-bit read mux with sel = rp.
- Push = in_valid & in_ready. On push: mem[wp] <= in_data, and wp <= wp + 1.
- Pop = out_valid & out_ready. On pop: rp <= rp + 1.
- Pointer arithmetic is modulo 8; 7 + 1 wraps to 0. No extra wrap bit is used; full and empty are distinguished only by cnt.
- Count update:
  - push only: cnt + 1;
  - pop only: cnt − 1;
  - push and pop together: unchanged;
  - neither: unchanged.
- Write decode: only the register addressed by wp loads, and only on push. All other registers hold.
- Full (cnt = 8):
  - in_ready = 0, so in_valid is ignored; no register, pointer or count changes.
  - A pop in the same cycle still happens. in_ready rises in the next cycle. There is no same-cycle bypass.
- Empty (cnt = 0):
  - out_valid = 0, so out_ready is ignored.
  - A push in the same cycle loads mem[wp]. The word appears on out_data with out_valid = 1 in the next cycle. There is no combinational flow-through.
- Simultaneous push and pop with 0 < cnt < 8: both happen. If rp = wp, the register being read is never the one being written, because that case only arises when cnt is 0 or 8.
- Reset has priority over push and pop in the same cycle. Reset in the middle of a stream discards all stored entries.

## Timing
- Reset values, visible the cycle after reset is sampled high:
  - wp = 0, rp = 0, cnt = 0;
  - mem0..mem7 = 16'h0000;
  - out_data = 16'h0000, out_valid = 0, in_ready = 1, count = 0.
- Latency from a push to visibility on out_data with out_valid: 1 cycle when the FIFO was empty. Otherwise the word waits behind the older entries.
- A pop advances the head on the next rising edge. out_data changes combinationally from the new rp.
- Sustained throughput: one push and one pop per cycle when 0 < cnt < 8.
- Handshake rules:
  - A producer holding in_valid high with in_ready low must keep in_data stable; the FIFO samples it only on a cycle where push is true.
  - out_data is stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset and idle:
  - Stimulus: assert reset for 2 cycles, then release; hold in_valid = 0 and out_ready = 0.
  - Required: count = 0, out_valid = 0, in_ready = 1, out_data = 16'h0000.
- Fill to full:
  - Stimulus: push 16'h1000..16'h1007 on 8 consecutive cycles with out_ready = 0, then offer 16'hDEAD.
  - Required: count steps 1..8; in_ready = 0 after the 8th push; 16'hDEAD is not stored; out_data = 16'h1000.
- Drain in order:
  - Stimulus: from full, hold out_ready = 1 for 8 cycles.
  - Required: out_data reads 16'h1000..16'h1007 in order; count then = 0 and out_valid = 0.
  - Continue holding out_ready = 1 for 2 more cycles: count stays 0.
- Wrap-around:
  - Stimulus: push 5 words, pop 5, then push 16'hA000..16'hA006.
  - Required: pointers wrap past 7; pops return 16'hA000..16'hA006 in order.
- Simultaneous push and pop:
  - Stimulus: with cnt = 3, push and pop in the same cycle.
  - Required: count stays 3 and the head advances.
  - Stimulus: with cnt = 8, push and pop in the same cycle.
  - Required: the pop happens, the push is ignored, count = 7.
  - Stimulus: with cnt = 0, push and pop in the same cycle.
  - Required: the push happens, count = 1, and out_valid rises the next cycle.
- Reset mid-stream:
  - Stimulus: with cnt = 4, assert reset together with in_valid = 1 and out_ready = 1.
  - Required: next cycle count = 0, out_valid = 0, out_data = 16'h0000; no entry survives.
